// File: rtl/multi_digit_updown_counter.sv
// rtl/multi_digit_updown_counter.sv - N-digit binary/BCD up/down counter with load, tc and wrap pulse
// Optional feature macro: MULTI_DIGIT_COUNTER_SATURATE_EN (hold at terminal value instead of wrapping)
module multi_digit_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                mstr_reset,
  input  logic                en,
  input  logic                cnt_type,
  input  logic                cnt_mode,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] out,
  output logic                tc,
  output logic                carry_out
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_ONES  = {W{1'b1}};
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] terminal;
  logic [W-1:0] reset_val;
  logic [W-1:0] bin_next;
  logic [W-1:0] bcd_next;
  logic [W-1:0] step_val;
  logic [W-1:0] load_clamped;
  logic [3:0]   digit;
  logic [3:0]   new_digit;
  logic         ripple;

  // Terminal and reset values depend only on the currently selected type/direction
  always_comb begin
    terminal  = cnt_mode ? '0 : (cnt_type ? ALL_NINES : ALL_ONES);
    reset_val = cnt_mode ? (cnt_type ? ALL_NINES : ALL_ONES) : '0;
  end

  assign tc = (out == terminal);

  // Plain binary step, wraps naturally modulo 2^W
  always_comb begin
    bin_next = cnt_mode ? (out - 1'b1) : (out + 1'b1);
  end

  // BCD digit ripple; nibbles above 9 are read as 9 so stale binary values settle into BCD
  always_comb begin
    bcd_next  = '0;
    ripple    = 1'b1;
    digit     = 4'd0;
    new_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = out[4*i +: 4];
      if (digit > 4'd9) digit = 4'd9;
      if (!ripple) begin
        new_digit = digit;
      end else if (!cnt_mode) begin
        if (digit == 4'd9) begin
          new_digit = 4'd0;
        end else begin
          new_digit = digit + 4'd1;
          ripple    = 1'b0;
        end
      end else begin
        if (digit == 4'd0) begin
          new_digit = 4'd9;
        end else begin
          new_digit = digit - 4'd1;
          ripple    = 1'b0;
        end
      end
      bcd_next[4*i +: 4] = new_digit;
    end
  end

  assign step_val = cnt_type ? bcd_next : bin_next;

  // Load value is forced into BCD range when counting in BCD
  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_type && (load_val[4*i +: 4] > 4'd9)) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  // Counter register: reset > load > count > hold; carry_out marks a wrap on this edge
  always_ff @(posedge clk) begin
    if (mstr_reset) begin
      out       <= reset_val;
      carry_out <= 1'b0;
    end else if (load) begin
      out       <= load_clamped;
      carry_out <= 1'b0;
    end else if (en) begin
`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
      if (!tc) out <= step_val;
      carry_out <= 1'b0;
`else
      out       <= step_val;
      carry_out <= tc;
`endif
    end else begin
      carry_out <= 1'b0;
    end
  end

endmodule
